// File: rtl/result_formatter_pkg.sv
// Shared definitions for the result formatter: ASCII constants, the
// formatter state enum and the BCD digit-count helper.
package AocPkg;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_NL   = 8'h0A;
  localparam logic [7:0] ASCII_E    = 8'h45;
  localparam logic [7:0] ASCII_R    = 8'h52;

  typedef enum logic [2:0] {
    FMT_IDLE,
    FMT_CONVERT,
    FMT_EMIT,
    FMT_NEWLINE,
    FMT_ERRMSG
  } Fmt_e;

  // Decimal digits needed for an unsigned value of the given width
  // (log10(2) ~= 0.30103).
  function automatic int max_digits(input int bits);
    return (bits * 30103) / 100000 + 1;
  endfunction

endpackage

// File: rtl/result_formatter_bcd_step.sv
// One double-dabble iteration: add 3 to every BCD nibble >= 5, then shift
// the whole BCD vector left by one, inserting the incoming binary bit.
// Ports:
//   bcd_i - current BCD vector (DIGITS nibbles)
//   bit_i - next binary bit, MSB first
//   bcd_o - BCD vector after add-3 and shift
module bcd_step #(
  parameter int DIGITS = 15
) (
  input  logic [4*DIGITS-1:0] bcd_i,
  input  logic                bit_i,
  output logic [4*DIGITS-1:0] bcd_o
);

  logic [4*DIGITS-1:0] adj;
  logic                unused_top_bit;

  always_comb begin
    adj = bcd_i;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_i[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = bcd_i[4*i +: 4] + 4'd3;
      end
    end
  end

  // The digit count is sized so the top nibble never reaches 8; its MSB
  // is always zero and is dropped by the shift.
  assign unused_top_bit = adj[4*DIGITS-1];
  assign bcd_o          = {adj[4*DIGITS-2:0], bit_i};

endmodule

// File: rtl/result_formatter.sv
// Captures the solver total on Start, converts it to decimal with a
// bit-serial double-dabble loop and streams the digits (leading zeros
// suppressed) plus a newline as ASCII over a valid/ready byte interface.
// ErrorIn on Start emits "ERR\n" instead.
// Ports:
//   Clk, Rst       - clock, synchronous active-high reset
//   Start, Value,
//   ErrorIn        - request, binary total, error flag (sampled in IDLE)
//   TxData/TxValid/
//   TxReady        - registered byte stream toward the UART
//   Busy           - high whenever not IDLE
//   Done           - one-cycle pulse after the final byte is accepted
module result_formatter
  import AocPkg::*;
#(
  parameter int VALUE_BITS = 48
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  Start,
  input  logic [VALUE_BITS-1:0] Value,
  input  logic                  ErrorIn,
  output logic [7:0]            TxData,
  output logic                  TxValid,
  input  logic                  TxReady,
  output logic                  Busy,
  output logic                  Done
);

  localparam int MAX_DIGITS = max_digits(VALUE_BITS);
  localparam int BW         = 4 * MAX_DIGITS;
  localparam int CW         = $clog2(VALUE_BITS);
  localparam int PW         = $clog2(MAX_DIGITS);

  Fmt_e                  state_q, state_d;
  logic [VALUE_BITS-1:0] shift_q, shift_d;
  logic [BW-1:0]         bcd_q, bcd_d, step_bcd;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [PW-1:0]         ptr_q, ptr_d, msd;
  logic [1:0]            idx_q, idx_d;
  logic [7:0]            tx_data_q, tx_data_d;
  logic                  tx_valid_q, tx_valid_d;
  logic                  done_q, done_d;
  logic                  hs;
  logic [3:0]            nib;

  bcd_step #(.DIGITS(MAX_DIGITS)) u_step (
    .bcd_i (bcd_q),
    .bit_i (shift_q[VALUE_BITS-1]),
    .bcd_o (step_bcd)
  );

  // Most significant nonzero digit of the freshly stepped BCD, so the
  // pointer is ready on the same edge the last bit is shifted in.
  always_comb begin
    msd = '0;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (step_bcd[4*i +: 4] != 4'd0) msd = PW'(i);
    end
  end

  assign hs = tx_valid_q & TxReady;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    case (state_q)
      FMT_IDLE: begin
        if (Start) begin
          if (ErrorIn) begin
            idx_d   = '0;
            state_d = FMT_ERRMSG;
          end else begin
            shift_d = Value;
            bcd_d   = '0;
            cnt_d   = '0;
            state_d = FMT_CONVERT;
          end
        end
      end
      FMT_CONVERT: begin
        shift_d = {shift_q[VALUE_BITS-2:0], 1'b0};
        bcd_d   = step_bcd;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CW'(VALUE_BITS - 1)) begin
          ptr_d   = msd;
          state_d = FMT_EMIT;
        end
      end
      FMT_EMIT: begin
        if (hs) begin
          if (ptr_q == '0) state_d = FMT_NEWLINE;
          else             ptr_d   = ptr_q - 1'b1;
        end
      end
      FMT_NEWLINE: begin
        if (hs) begin
          done_d  = 1'b1;
          state_d = FMT_IDLE;
        end
      end
      FMT_ERRMSG: begin
        if (hs) begin
          if (idx_q == 2'd3) begin
            done_d  = 1'b1;
            state_d = FMT_IDLE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = FMT_IDLE;
    endcase
  end

  // Output byte is computed from the next state so TxData/TxValid can be
  // registered yet still present the new byte right after a handshake.
  always_comb begin
    nib = '0;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (ptr_d == PW'(i)) nib = bcd_d[4*i +: 4];
    end
  end

  always_comb begin
    tx_valid_d = 1'b0;
    tx_data_d  = 8'h00;
    case (state_d)
      FMT_EMIT: begin
        tx_valid_d = 1'b1;
        tx_data_d  = ASCII_ZERO + {4'h0, nib};
      end
      FMT_NEWLINE: begin
        tx_valid_d = 1'b1;
        tx_data_d  = ASCII_NL;
      end
      FMT_ERRMSG: begin
        tx_valid_d = 1'b1;
        if (idx_d == 2'd0)      tx_data_d = ASCII_E;
        else if (idx_d == 2'd3) tx_data_d = ASCII_NL;
        else                    tx_data_d = ASCII_R;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q    <= FMT_IDLE;
      shift_q    <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      ptr_q      <= '0;
      idx_q      <= '0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
      idx_q      <= idx_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      done_q     <= done_d;
    end
  end

  assign TxData  = tx_data_q;
  assign TxValid = tx_valid_q;
  assign Busy    = (state_q != FMT_IDLE);
  assign Done    = done_q;

endmodule

// File: tb/tb_result_formatter.sv
module tb_result_formatter;

  localparam int VB = 48;

  logic          Clk = 1'b0;
  logic          Rst = 1'b1;
  logic          Start = 1'b0;
  logic          ErrorIn = 1'b0;
  logic          TxReady = 1'b0;
  logic [VB-1:0] Value = '0;
  logic [7:0]    TxData;
  logic          TxValid;
  logic          Busy;
  logic          Done;

  result_formatter #(.VALUE_BITS(VB)) dut (
    .Clk     (Clk),
    .Rst     (Rst),
    .Start   (Start),
    .Value   (Value),
    .ErrorIn (ErrorIn),
    .TxData  (TxData),
    .TxValid (TxValid),
    .TxReady (TxReady),
    .Busy    (Busy),
    .Done    (Done)
  );

  always #5 Clk = ~Clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model: expected byte string, latency to first byte, busy.
  logic [7:0] m_q[$];
  bit         m_busy = 1'b0;
  int         m_lat = 0;
  bit         m_done = 1'b0;
  bit         chk_en = 1'b0;
  bit         ev;

  logic [7:0] rx[$];
  int         rx_cyc[$];
  int         cyc = 0;
  int         acc_cyc = 0;
  int         done_cnt = 0;

  bit         rnd_ready = 1'b0;
  bit         ready_fix = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic string vis(input string s);
    string r = "";
    for (int i = 0; i < s.len(); i++) begin
      if (s[i] == 8'h0A) r = {r, "<NL>"};
      else               r = $sformatf("%s%c", r, s[i]);
    end
    return r;
  endfunction

  function automatic string rx_str();
    string s = "";
    foreach (rx[i]) s = $sformatf("%s%c", s, rx[i]);
    return s;
  endfunction

  task automatic chk_str(input string name, input string act, input string exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got \"%s\" expected \"%s\"", name, vis(act), vis(exp));
    end
  endtask

  function automatic void load_expected(input logic [VB-1:0] v, input bit err);
    longint unsigned x;
    m_q.delete();
    if (err) begin
      m_q.push_back(8'h45);
      m_q.push_back(8'h52);
      m_q.push_back(8'h52);
    end else begin
      x = 64'(v);
      do begin
        m_q.push_front(8'(64'h30 + x % 10));
        x = x / 10;
      end while (x != 0);
    end
    m_q.push_back(8'h0A);
  endfunction

  always @(posedge Clk) begin
    cyc++;
    if (Rst) begin
      m_busy = 1'b0;
      m_lat  = 0;
      m_done = 1'b0;
      m_q.delete();
    end else begin
      if (TxValid && TxReady) begin
        rx.push_back(TxData);
        rx_cyc.push_back(cyc);
      end
      m_done = 1'b0;
      if (!m_busy) begin
        if (Start) begin
          load_expected(Value, ErrorIn);
          m_lat   = ErrorIn ? 0 : VB;
          m_busy  = 1'b1;
          acc_cyc = cyc;
        end
      end else if (m_lat > 0) begin
        m_lat--;
      end else if (TxReady) begin
        void'(m_q.pop_front());
        if (m_q.size() == 0) begin
          m_busy = 1'b0;
          m_done = 1'b1;
        end
      end
    end
  end

  always @(negedge Clk) begin
    TxReady = rnd_ready ? 1'($urandom_range(0, 1)) : ready_fix;
  end

  always @(negedge Clk) begin
    if (chk_en) begin
      ev = m_busy && (m_lat == 0) && (m_q.size() > 0);
      chk("txvalid", TxValid, ev);
      if (ev) chk("txdata", TxData, m_q[0]);
      chk("busy", Busy, m_busy);
      chk("done", Done, m_done);
      if (Done) done_cnt++;
    end
  end

  task automatic send(input logic [VB-1:0] v, input bit err);
    rx.delete();
    rx_cyc.delete();
    done_cnt = 0;
    Value   = v;
    ErrorIn = err;
    Start   = 1'b1;
    @(negedge Clk);
    Start   = 1'b0;
    ErrorIn = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while ((m_busy || Busy || m_done) && n < budget) begin
      @(negedge Clk);
      n++;
    end
    chk({name, "_timeout"}, 64'(n >= budget), 64'd0);
  endtask

  initial begin
    repeat (3) @(negedge Clk);
    chk("rst_txvalid", TxValid, 1'b0);
    chk("rst_txdata", TxData, 8'h00);
    chk("rst_busy", Busy, 1'b0);
    chk("rst_done", Done, 1'b0);
    Rst    = 1'b0;
    chk_en = 1'b1;

    // 357, sink always ready
    ready_fix = 1'b1;
    @(negedge Clk);
    send(48'd357, 1'b0);
    wait_idle(200, "v357");
    chk_str("v357_str", rx_str(), "357\n");
    chk("v357_latency", (rx.size() > 0) ? 64'(rx_cyc[0] - acc_cyc) : 64'hFFFF, 64'd49);
    chk("v357_back2back", (rx.size() >= 4) ? 64'(rx_cyc[3] - rx_cyc[0]) : 64'hFFFF, 64'd3);
    chk("v357_done_cnt", 64'(done_cnt), 64'd1);

    send(48'd0, 1'b0);
    wait_idle(200, "v0");
    chk_str("v0_str", rx_str(), "0\n");

    send({VB{1'b1}}, 1'b0);
    wait_idle(200, "vmax");
    chk_str("vmax_str", rx_str(), "281474976710655\n");
    chk("vmax_len", 64'(rx.size()), 64'd16);

    // 1000 with a stalling sink
    rnd_ready = 1'b1;
    send(48'd1000, 1'b0);
    wait_idle(2000, "v1000");
    chk_str("v1000_str", rx_str(), "1000\n");
    rnd_ready = 1'b0;
    @(negedge Clk);

    // Error path with a second Start mid-string
    send(48'd12345, 1'b1);
    @(negedge Clk);
    Value = 48'd7;
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    wait_idle(200, "err");
    chk_str("err_str", rx_str(), "ERR\n");
    chk("err_latency", (rx.size() > 0) ? 64'(rx_cyc[0] - acc_cyc) : 64'hFFFF, 64'd1);
    chk("err_done_cnt", 64'(done_cnt), 64'd1);

    // Reset during the second digit of 98765
    send(48'd98765, 1'b0);
    begin
      int n = 0;
      while (rx.size() < 1 && n < 200) begin
        @(negedge Clk);
        n++;
      end
      chk("rst_mid_timeout", 64'(n >= 200), 64'd0);
    end
    chk_str("rst_mid_prefix", rx_str(), "9");
    Rst = 1'b1;
    @(negedge Clk);
    chk("rst_mid_txvalid", TxValid, 1'b0);
    chk("rst_mid_busy", Busy, 1'b0);
    Rst = 1'b0;
    @(negedge Clk);
    send(48'd5, 1'b0);
    wait_idle(200, "v5");
    chk_str("v5_str", rx_str(), "5\n");

    // Randomized traffic: starts while busy, errors, stalls, rare resets
    rnd_ready = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      Start   = ($urandom_range(0, 9) == 0);
      ErrorIn = ($urandom_range(0, 5) == 0);
      Value   = VB'({$urandom, $urandom} >> $urandom_range(0, 60));
      Rst     = ($urandom_range(0, 799) == 0);
      @(negedge Clk);
    end
    Start = 1'b0;
    Rst   = 1'b0;
    wait_idle(2000, "rand");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/result_formatter.md
# result_formatter

Downstream stage of the puzzle solver. When the solver reports completion, this block captures its binary total, converts it to decimal with a sequential shift-add-3 (double-dabble) loop, and emits the digits as ASCII over a valid/ready byte stream toward the UART transmitter. Leading zeros are suppressed and the output ends with a newline. A solver error produces the fixed string "ERR\n" instead.

## Interface

Parameters:
- `VALUE_BITS`, default 48: width of the binary total. Use 32 for part 1 and 48 for part 2.
- `MAX_DIGITS`, derived as (VALUE_BITS*30103)/100000+1: number of BCD digits. This is 15 for 48 bits and 10 for 32 bits. It is not overridable.

Ports (name, direction, width, meaning):
- `Clk`, in, 1: the single clock.
- `Rst`, in, 1: reset, synchronous and active-high.
- `Start`, in, 1: single-cycle request. Only sampled in IDLE.
- `Value`, in, VALUE_BITS: binary total, latched on the accepted Start.
- `ErrorIn`, in, 1: latched with Start. When high, Value is ignored and "ERR\n" is emitted.
- `TxData`, out, 8: ASCII byte.
- `TxValid`, out, 1: TxData is valid.
- `TxReady`, in, 1: sink accepts the byte when TxValid and TxReady are both high.
- `Busy`, out, 1: high in every state except IDLE.
- `Done`, out, 1: one-cycle pulse after the final byte is accepted.

## Operation

- States: IDLE, CONVERT, EMIT, NEWLINE, ERRMSG.
- **IDLE**
  - If Start is high and ErrorIn is high: go to ERRMSG with the character index set to 0.
  - If Start is high and ErrorIn is low: latch Value into the shift register, clear the BCD register (4*MAX_DIGITS bits) and the bit counter, then go to CONVERT.
- **CONVERT**, one bit per cycle:
  - Every BCD nibble that is ≥5 gets +3.
  - Then {BCD, shift} is shifted left by 1.
  - After VALUE_BITS cycles, set the digit pointer to the index of the most significant nonzero nibble (priority encoder, same cycle). If every nibble is zero, the pointer is 0. Go to EMIT.
- **EMIT**
  - TxData = 8'h30 + nibble[pointer].
  - On handshake: if the pointer is 0, go to NEWLINE; otherwise decrement the pointer.
- **NEWLINE**: TxData = 8'h0A. On handshake, pulse Done and go to IDLE.
- **ERRMSG**: emit 'E', 'R', 'R', 8'h0A in order, advancing the index on each handshake. On the final handshake, pulse Done and go to IDLE.
- Start received while Busy is ignored. It is neither queued nor does it modify any state.
- Arithmetic is unsigned. Nibble values after add-3 never exceed 4'hC, so no carry out of a nibble is possible.

## Timing

- Reset values: TxValid=0, TxData=8'h00, Busy=0, Done=0, state IDLE.
- Rst asserted in any state, including mid-handshake: on the next edge all outputs take their reset values and any partial string is abandoned.
- Start accepted at edge N:
  - Busy is high from N+1.
  - CONVERT occupies edges N+1 through N+VALUE_BITS.
  - TxValid rises at N+VALUE_BITS+1 (cycle 49 for 48 bits).
- ERRMSG path: TxValid rises at N+1.
- TxValid and TxData are registered and held stable until the handshake. TxValid never drops without a handshake, except on Rst.
- Back-to-back bytes: with TxReady held high, one byte is sent per cycle.
- Done rises the cycle after the final handshake and is high for exactly one cycle. Busy falls in that same cycle.
- Start on the cycle Done is high is accepted, because the block is in IDLE then.

## Structure

- Shared package `AocPkg` receives:
  - constants ASCII_ZERO (8'h30), ASCII_NL (8'h0A), ASCII_E (8'h45), ASCII_R (8'h52);
  - the Fmt_e state enum;
  - a function computing MAX_DIGITS from the bit width.
- One sub-module, `bcd_step`: purely combinational. It takes the current BCD vector and the incoming bit and returns the add-3-and-shift result for all digits.
- The top level holds the FSM, registers, priority encoder and output mux.

## Test plan

- Value=357, TxReady=1: bytes 8'h33, 8'h35, 8'h37, 8'h0A on four consecutive cycles starting 49 cycles after Start; Done pulses once.
- Value=0: bytes "0\n" only (8'h30, 8'h0A).
- Value=2^48-1: "281474976710655\n", 16 bytes, no leading zero.
- Value=1000, TxReady toggling pseudo-randomly: TxData and TxValid stay stable while stalled; the received stream is "1000\n".
- ErrorIn=1 with Start, Value=12345: "ERR\n" starting at N+1; a second Start sent mid-string is ignored.
- Rst asserted during the second digit of Value=98765: TxValid=0 and Busy=0 the next cycle; a new Start with Value=5 then yields "5\n".
